keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and is the input-side counterpart of the multiplexed seven-segment display path.
- Drives one keypad column low at a time, the same way the display path drives anodes, and reads the row lines back.
- Synchronises and debounces the row lines, rejects multi-key presses, and emits one 4-bit key code per physical press.
- Its output feeds the calculator operand/operator entry logic.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven; legal range >= 4 so rows settle through the synchroniser.
- DEBOUNCE_SCANS, 3, consecutive full scans that must agree before a press or release is accepted; legal range 1..15.

Ports:
- nclk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- row  in  4  keypad row lines; active-low, externally pulled up, asynchronous to nclk.
- col  out  4  keypad column drive; active-low one-hot, col[i]=0 selects column i.
- key_code  out  4  code of the last accepted key; holds its value until the next accepted key.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high while the accepted key is considered pressed.

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, state=IDLE; all counters and synchroniser flops cleared.
- row passes through a 2-flop synchroniser into row_s.
- div counter counts 0..SCAN_DIV-1. At div==SCAN_DIV-1, row_s is sampled for the current column, then col_idx advances 0->1->2->3->0 and col rotates left.
- Scan end occurs at the sample with col_idx==3. The scan result is evaluated on the following cycle.
- Key map (row r, column c) -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Scan result is one of:
  - NONE: zero pressed bits.
  - SINGLE(code): exactly one pressed bit.
  - MULTI: two or more pressed bits. MULTI is treated as NONE, which gives ghost/chord rejection.
- cand register holds the last SINGLE code; cnt register is the agreement counter.
- FSM, evaluated only at scan-end:
  - IDLE: on SINGLE(k), cand=k, cnt=1, go to DEBOUNCE. With DEBOUNCE_SCANS==1, accept immediately instead.
  - DEBOUNCE:
    - SINGLE(cand): cnt++; when cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE/MULTI: go to IDLE.
  - Accept: key_code=cand, key_valid=1 for exactly that cycle, key_held=1, go to PRESSED, cnt=0.
  - PRESSED:
    - Any SINGLE or MULTI: cnt=0. A different single key never produces a new code without a release first.
    - NONE: cnt++; when cnt reaches DEBOUNCE_SCANS, key_held=0 and go to IDLE.
- key_valid is never high on two consecutive cycles. It can assert at most once per DEBOUNCE_SCANS+1 scans.
- Latency: a clean press that is stable from the start of a scan gives key_valid 1 cycle after the scan-end of the DEBOUNCE_SCANS-th agreeing scan. Worst case is (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles from the row change.
- rst asserted mid-operation: the next edge returns every state to the reset values, and a pending key_valid is suppressed. Scanning restarts at column 0 on the first cycle after rst deasserts.
- col is always exactly one-hot low, including during reset.

Test Plan:
- Reset: assert rst for 3 cycles with SCAN_DIV=4 -> col=1110, key_valid=0, key_held=0, key_code=0. After release, col steps 1110,1101,1011,0111 every 4 cycles and wraps.
- Clean press: hold key "5" (row1 low while col1 is low) from cycle 0 with DEBOUNCE_SCANS=3 -> exactly one key_valid pulse with key_code=4'h5, within 68 cycles; key_held stays 1 while the key is held, with no further pulses.
- Bounce: toggle row1 every 5 cycles for 100 cycles, then hold it -> no key_valid during the toggling; one pulse with code 5 after the hold is stable for 3 scans.
- Chord: hold "1" and "6" together -> no key_valid. Release "6" while keeping "1" -> one pulse with key_code=4'h1.
- Release and switch: accept "#", release for 3 scans -> key_held falls and key_code stays F. Then press "0" -> a new pulse with key_code=4'h0. Switching "#"->"0" with no gap -> no pulse until "0" is released and pressed again.
- Reset mid-debounce: hold "D", assert rst during the 2nd agreeing scan -> no key_valid, all outputs at reset values; after rst deasserts, a full 3-scan debounce is needed before the pulse with code D.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with row synchroniser,
// scan-level debounce and chord rejection; one code per press.
module keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       nclk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [3:0] DebTarget = 4'(DEBOUNCE_SCANS);

   localparam logic [3:0] KeyMap [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED
   } stateT;

   stateT           state;
   stateT           stateNext;
   logic [3:0]      rowMeta;
   logic [3:0]      rowS;
   logic [DivW-1:0] div;
   logic [1:0]      colIdx;
   logic [3:0]      colHits [4];
   logic            scanDone;
   logic [3:0]      cand;
   logic [3:0]      candNext;
   logic [3:0]      cnt;
   logic [3:0]      cntNext;
   logic [3:0]      keyCodeNext;
   logic            keyValidNext;
   logic            keyHeldNext;
   logic [4:0]      hitCount;
   logic [3:0]      hitCode;
   logic            single;
   logic            none;
   logic            accept;
   logic [3:0]      acceptCode;

   assign col = ~(4'b0001 << colIdx);

   // Rows are sampled on the last cycle of each column so the
   // synchroniser has settled after the column change.
   always_ff @(posedge nclk) begin
      if (rst) begin
         rowMeta  <= '0;
         rowS     <= '0;
         div      <= '0;
         colIdx   <= '0;
         scanDone <= 1'b0;
         for (int c = 0; c < 4; c++) begin
            colHits[c] <= '0;
         end
      end else begin
         rowMeta  <= row;
         rowS     <= rowMeta;
         scanDone <= 1'b0;
         if (div == DivLast) begin
            div             <= '0;
            colIdx          <= colIdx + 2'd1;
            colHits[colIdx] <= ~rowS;
            scanDone        <= (colIdx == 2'd3);
         end else begin
            div <= div + DivW'(1);
         end
      end
   end

   always_comb begin
      hitCount = '0;
      hitCode  = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (colHits[c][r]) begin
               hitCount = hitCount + 5'd1;
               hitCode  = KeyMap[{r[1:0], c[1:0]}];
            end
         end
      end
   end

   assign none   = (hitCount == 5'd0);
   assign single = (hitCount == 5'd1);

   always_comb begin
      stateNext    = state;
      candNext     = cand;
      cntNext      = cnt;
      keyCodeNext  = key_code;
      keyValidNext = 1'b0;
      keyHeldNext  = key_held;
      accept       = 1'b0;
      acceptCode   = cand;
      if (scanDone) begin
         unique case (state)
            IDLE: begin
               if (single) begin
                  candNext  = hitCode;
                  cntNext   = 4'd1;
                  stateNext = DEBOUNCE;
                  if (DebTarget == 4'd1) begin
                     accept     = 1'b1;
                     acceptCode = hitCode;
                  end
               end
            end
            DEBOUNCE: begin
               if (single && hitCode == cand) begin
                  cntNext = cnt + 4'd1;
                  if (cntNext == DebTarget) begin
                     accept = 1'b1;
                  end
               end else if (single) begin
                  candNext = hitCode;
                  cntNext  = 4'd1;
               end else begin
                  stateNext = IDLE;
                  cntNext   = '0;
               end
            end
            PRESSED: begin
               // Any activity, even a different key, restarts release.
               if (!none) begin
                  cntNext = '0;
               end else begin
                  cntNext = cnt + 4'd1;
                  if (cntNext == DebTarget) begin
                     stateNext   = IDLE;
                     keyHeldNext = 1'b0;
                     cntNext     = '0;
                  end
               end
            end
            default: begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         endcase
         if (accept) begin
            keyCodeNext  = acceptCode;
            keyValidNext = 1'b1;
            keyHeldNext  = 1'b1;
            stateNext    = PRESSED;
            cntNext      = '0;
         end
      end
   end

   always_ff @(posedge nclk) begin
      if (rst) begin
         state     <= IDLE;
         cand      <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= stateNext;
         cand      <= candNext;
         cnt       <= cntNext;
         key_code  <= keyCodeNext;
         key_valid <= keyValidNext;
         key_held  <= keyHeldNext;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated keypad matrix plus a
// scan-level reference model of press/release acceptance.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int SCAN     = 4 * SCAN_DIV;

   localparam logic [3:0] KEYS [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   logic       nclk = 1'b0;
   logic       rst  = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   bit keyDown [4][4];
   bit seen    [4][4];

   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   int bounceT = 0;
   int totPulses = 0;
   int firstPulse = -1;
   logic [3:0] lastCode = '0;
   bit prevValid = 1'b0;

   bit         mHeld;
   int         mAgree;
   int         mQuiet;
   logic [3:0] mCand;
   logic [3:0] mCode;
   int         expPulses;
   logic [3:0] expPulseCode;

   keypad_scanner #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_SCANS(DEB)
   ) dut (
      .nclk(nclk),
      .rst(rst),
      .row(row),
      .col(col),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_held(key_held)
   );

   always #5 nclk = ~nclk;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keyDown[r][c] && col[c] == 1'b0) begin
               row[r] = 1'b0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic clearKeys();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            keyDown[r][c] = 1'b0;
         end
      end
   endtask

   task automatic modelReset();
      mHeld        = 1'b0;
      mAgree       = 0;
      mQuiet       = 0;
      mCand        = '0;
      mCode        = '0;
      expPulses    = 0;
      expPulseCode = '0;
      prevValid    = 1'b0;
   endtask

   // One full scan's worth of key activity applied to the press rules.
   task automatic modelStep();
      int n;
      logic [3:0] code;
      n = 0;
      code = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (seen[r][c]) begin
               n++;
               code = KEYS[r][c];
            end
         end
      end
      expPulses = 0;
      if (!mHeld) begin
         if (n == 1) begin
            if (mAgree > 0 && code == mCand) begin
               mAgree++;
            end else begin
               mCand  = code;
               mAgree = 1;
            end
            if (mAgree >= DEB) begin
               mHeld        = 1'b1;
               mCode        = mCand;
               expPulses    = 1;
               expPulseCode = mCand;
               mAgree       = 0;
               mQuiet       = 0;
            end
         end else begin
            mAgree = 0;
         end
      end else if (n == 0) begin
         mQuiet++;
         if (mQuiet >= DEB) begin
            mHeld  = 1'b0;
            mQuiet = 0;
            mAgree = 0;
         end
      end else begin
         mQuiet = 0;
      end
   endtask

   task automatic runScan(input bit bounce);
      int pulses;
      logic [3:0] pcode;
      logic [3:0] expCol;
      bit b2b;
      pulses = 0;
      pcode  = '0;
      b2b    = 1'b0;
      for (int j = 0; j < SCAN; j++) begin
         if (bounce) begin
            keyDown[1][1] = ((bounceT / 5) % 2) == 0;
            bounceT++;
         end
         for (int c = 0; c < 4; c++) begin
            if (j == c * SCAN_DIV + SCAN_DIV - 3) begin
               for (int r = 0; r < 4; r++) begin
                  seen[r][c] = keyDown[r][c];
               end
            end
         end
         @(negedge nclk);
         if (j % SCAN_DIV == 1) begin
            expCol = ~(4'b0001 << (j / SCAN_DIV));
            checks++;
            if (col !== expCol) begin
               $display("FAIL col_step: got %b expected %b", col, expCol);
            end else begin
               passes++;
            end
         end
         if (key_valid === 1'b1) begin
            pulses++;
            totPulses++;
            pcode    = key_code;
            lastCode = key_code;
            if (prevValid) b2b = 1'b1;
            if (firstPulse < 0) firstPulse = cyc;
         end
         prevValid = (key_valid === 1'b1);
         cyc++;
         @(posedge nclk);
         #1;
      end
      checks++;
      if (pulses !== expPulses) begin
         $display("FAIL pulse_count: got %0d expected %0d", pulses, expPulses);
      end else begin
         passes++;
      end
      if (pulses == 1 && expPulses == 1) begin
         checks++;
         if (pcode !== expPulseCode) begin
            $display("FAIL pulse_code: got %h expected %h", pcode, expPulseCode);
         end else begin
            passes++;
         end
      end
      checks++;
      if (b2b !== 1'b0) begin
         $display("FAIL valid_b2b: got %b expected 0", b2b);
      end else begin
         passes++;
      end
      checks++;
      if (key_held !== mHeld) begin
         $display("FAIL key_held: got %b expected %b", key_held, mHeld);
      end else begin
         passes++;
      end
      checks++;
      if (key_code !== mCode) begin
         $display("FAIL key_code: got %h expected %h", key_code, mCode);
      end else begin
         passes++;
      end
      modelStep();
   endtask

   task automatic test_reset();
      clearKeys();
      rst = 1'b1;
      repeat (3) begin
         @(posedge nclk);
         #1;
      end
      checks += 4;
      if (col !== 4'b1110) $display("FAIL rst_col: got %b expected 1110", col);
      else passes++;
      if (key_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", key_valid);
      else passes++;
      if (key_held !== 1'b0) $display("FAIL rst_held: got %b expected 0", key_held);
      else passes++;
      if (key_code !== 4'h0) $display("FAIL rst_code: got %h expected 0", key_code);
      else passes++;
      rst = 1'b0;
      modelReset();
      runScan(1'b0);
      runScan(1'b0);
   endtask

   task automatic test_clean_press();
      int p0;
      int c0;
      p0 = totPulses;
      c0 = cyc;
      firstPulse = -1;
      keyDown[1][1] = 1'b1;
      repeat (6) runScan(1'b0);
      checks += 4;
      if (totPulses - p0 !== 1) $display("FAIL clean_count: got %0d expected 1", totPulses - p0);
      else passes++;
      if (lastCode !== 4'h5) $display("FAIL clean_code: got %h expected 5", lastCode);
      else passes++;
      if (firstPulse < 0 || firstPulse - c0 > 68) $display("FAIL clean_latency: got %0d expected <=68", firstPulse - c0);
      else passes++;
      if (key_held !== 1'b1) $display("FAIL clean_held: got %b expected 1", key_held);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   task automatic test_bounce();
      int p0;
      p0 = totPulses;
      bounceT = 0;
      repeat (6) runScan(1'b1);
      checks++;
      if (totPulses - p0 !== 0) $display("FAIL bounce_quiet: got %0d expected 0", totPulses - p0);
      else passes++;
      keyDown[1][1] = 1'b1;
      repeat (5) runScan(1'b0);
      checks += 2;
      if (totPulses - p0 !== 1) $display("FAIL bounce_count: got %0d expected 1", totPulses - p0);
      else passes++;
      if (lastCode !== 4'h5) $display("FAIL bounce_code: got %h expected 5", lastCode);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   task automatic test_chord();
      int p0;
      p0 = totPulses;
      keyDown[0][0] = 1'b1;
      keyDown[1][2] = 1'b1;
      repeat (5) runScan(1'b0);
      checks++;
      if (totPulses - p0 !== 0) $display("FAIL chord_reject: got %0d expected 0", totPulses - p0);
      else passes++;
      keyDown[1][2] = 1'b0;
      repeat (5) runScan(1'b0);
      checks += 2;
      if (totPulses - p0 !== 1) $display("FAIL chord_count: got %0d expected 1", totPulses - p0);
      else passes++;
      if (lastCode !== 4'h1) $display("FAIL chord_code: got %h expected 1", lastCode);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   task automatic test_reset_mid();
      int p0;
      keyDown[3][3] = 1'b1;
      runScan(1'b0);
      for (int j = 0; j < 8; j++) begin
         @(negedge nclk);
         checks++;
         if (key_valid !== 1'b0) $display("FAIL mid_valid: got %b expected 0", key_valid);
         else passes++;
         @(posedge nclk);
         #1;
      end
      rst = 1'b1;
      repeat (3) begin
         @(posedge nclk);
         #1;
      end
      checks += 4;
      if (col !== 4'b1110) $display("FAIL mid_col: got %b expected 1110", col);
      else passes++;
      if (key_valid !== 1'b0) $display("FAIL mid_rvalid: got %b expected 0", key_valid);
      else passes++;
      if (key_held !== 1'b0) $display("FAIL mid_held: got %b expected 0", key_held);
      else passes++;
      if (key_code !== 4'h0) $display("FAIL mid_code: got %h expected 0", key_code);
      else passes++;
      rst = 1'b0;
      modelReset();
      p0 = totPulses;
      repeat (3) runScan(1'b0);
      checks++;
      if (totPulses - p0 !== 0) $display("FAIL mid_early: got %0d expected 0", totPulses - p0);
      else passes++;
      runScan(1'b0);
      checks += 2;
      if (totPulses - p0 !== 1) $display("FAIL mid_count: got %0d expected 1", totPulses - p0);
      else passes++;
      if (lastCode !== 4'hD) $display("FAIL mid_pcode: got %h expected d", lastCode);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   task automatic test_release_switch();
      int p0;
      p0 = totPulses;
      keyDown[3][2] = 1'b1;
      repeat (4) runScan(1'b0);
      clearKeys();
      repeat (4) runScan(1'b0);
      checks += 3;
      if (key_held !== 1'b0) $display("FAIL rel_held: got %b expected 0", key_held);
      else passes++;
      if (key_code !== 4'hF) $display("FAIL rel_code: got %h expected f", key_code);
      else passes++;
      if (totPulses - p0 !== 1) $display("FAIL rel_count: got %0d expected 1", totPulses - p0);
      else passes++;
      keyDown[3][1] = 1'b1;
      repeat (4) runScan(1'b0);
      checks += 2;
      if (totPulses - p0 !== 2) $display("FAIL zero_count: got %0d expected 2", totPulses - p0);
      else passes++;
      if (lastCode !== 4'h0) $display("FAIL zero_code: got %h expected 0", lastCode);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
      p0 = totPulses;
      keyDown[3][2] = 1'b1;
      repeat (4) runScan(1'b0);
      keyDown[3][2] = 1'b0;
      keyDown[3][1] = 1'b1;
      repeat (5) runScan(1'b0);
      checks++;
      if (totPulses - p0 !== 1) $display("FAIL switch_block: got %0d expected 1", totPulses - p0);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
      keyDown[3][1] = 1'b1;
      repeat (4) runScan(1'b0);
      checks += 2;
      if (totPulses - p0 !== 2) $display("FAIL switch_count: got %0d expected 2", totPulses - p0);
      else passes++;
      if (lastCode !== 4'h0) $display("FAIL switch_code: got %h expected 0", lastCode);
      else passes++;
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   task automatic test_random();
      int mode;
      int len;
      int p1;
      int p2;
      for (int seg = 0; seg < 40; seg++) begin
         clearKeys();
         mode = $urandom_range(0, 3);
         p1 = $urandom_range(0, 15);
         p2 = (p1 + $urandom_range(1, 15)) % 16;
         if (mode != 0) keyDown[p1 / 4][p1 % 4] = 1'b1;
         if (mode == 3) keyDown[p2 / 4][p2 % 4] = 1'b1;
         len = $urandom_range(1, 5);
         repeat (len) runScan(1'b0);
      end
      clearKeys();
      repeat (4) runScan(1'b0);
   endtask

   initial begin
      clearKeys();
      modelReset();
      @(posedge nclk);
      #1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_chord();
      test_reset_mid();
      test_release_switch();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
